// File: rtl/id_pkg.sv
// Shared constants and scoreboard entry type for the decode stage.
// No logic; imported by the decode-stage interface, top and bypass mux.
package id_pkg;
  localparam int REG_ADDR_W = 5;
  localparam logic [31:0] NOP_INST = 32'h0000_0015;

  typedef struct packed {
    logic                  vld;
    logic [REG_ADDR_W-1:0] addr;
  } sb_entry_t;
endpackage

// File: rtl/id_stage_pipe_if.sv
// Fetch/decode/execute-side signal bundle for the decode stage.
// master drives stage inputs; slave is the stage itself.
interface id_stage_pipe_if #(
  parameter int DATA_W    = 32,
  parameter int INST_W    = 32,
  parameter int NUM_SLOTS = 2,
  parameter int NUM_FWD   = 2
);
  import id_pkg::*;

  logic                          stall_in;
  logic                          squash;
  logic [INST_W-1:0]             inst_in;
  logic [NUM_SLOTS*DATA_W-1:0]   slot_in;
  logic [INST_W-1:0]             inst_q;
  logic [NUM_SLOTS*DATA_W-1:0]   slot_q;
  logic                          valid_q;
  logic [REG_ADDR_W-1:0]         rs1_addr;
  logic [REG_ADDR_W-1:0]         rs2_addr;
  logic                          is_load;
  logic [REG_ADDR_W-1:0]         dest_addr;
  logic [DATA_W-1:0]             rf_a;
  logic [DATA_W-1:0]             rf_b;
  logic                          wb_we;
  logic [REG_ADDR_W-1:0]         wb_addr;
  logic [DATA_W-1:0]             wb_data;
  logic [NUM_FWD-1:0]            fwd_valid;
  logic [NUM_FWD*REG_ADDR_W-1:0] fwd_addr;
  logic [NUM_FWD*DATA_W-1:0]     fwd_data;
  logic [DATA_W-1:0]             op_a;
  logic [DATA_W-1:0]             op_b;
  logic                          hazard_stall;
  logic                          is_branch;
  logic                          branch_ne;
  logic [DATA_W-1:0]             imm;
  logic                          branch_taken;
  logic [DATA_W-1:0]             branch_target;

  modport master (
    output stall_in, squash, inst_in, slot_in, rs1_addr, rs2_addr, is_load, dest_addr,
           rf_a, rf_b, wb_we, wb_addr, wb_data, fwd_valid, fwd_addr, fwd_data,
           is_branch, branch_ne, imm,
    input  inst_q, slot_q, valid_q, op_a, op_b, hazard_stall, branch_taken, branch_target
  );

  modport slave (
    input  stall_in, squash, inst_in, slot_in, rs1_addr, rs2_addr, is_load, dest_addr,
           rf_a, rf_b, wb_we, wb_addr, wb_data, fwd_valid, fwd_addr, fwd_data,
           is_branch, branch_ne, imm,
    output inst_q, slot_q, valid_q, op_a, op_b, hazard_stall, branch_taken, branch_target
  );
endinterface

// File: rtl/operand_bypass_mux.sv
// Priority operand select: fwd[0..N-1], then writeback, then register file; r0 always rf.
// Purely combinational, no backpressure.
module operand_bypass_mux
  import id_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int NUM_FWD = 2
) (
  input  logic [REG_ADDR_W-1:0]         src_addr,
  input  logic [NUM_FWD-1:0]            fwd_valid,
  input  logic [NUM_FWD*REG_ADDR_W-1:0] fwd_addr,
  input  logic [NUM_FWD*DATA_W-1:0]     fwd_data,
  input  logic                          wb_we,
  input  logic [REG_ADDR_W-1:0]         wb_addr,
  input  logic [DATA_W-1:0]             wb_data,
  input  logic [DATA_W-1:0]             rf_data,
  output logic [DATA_W-1:0]             operand
);
  logic hit;

  always_comb begin
    operand = rf_data;
    hit     = 1'b0;
    if (src_addr != '0) begin
      for (int i = 0; i < NUM_FWD; i++) begin
        if (!hit && fwd_valid[i] && fwd_addr[i*REG_ADDR_W +: REG_ADDR_W] == src_addr) begin
          operand = fwd_data[i*DATA_W +: DATA_W];
          hit     = 1'b1;
        end
      end
      if (!hit && wb_we && wb_addr == src_addr) begin
        operand = wb_data;
      end
    end
  end
endmodule

// File: rtl/id_stage_pipe.sv
// Decode pipeline register with operand bypass and load-use scoreboard; 1-cycle register, 0-cycle operands.
// Holds on stall_in or its own hazard_stall; ID_BRANCH_RESOLVE_EN adds decode-time branch resolution.
module id_stage_pipe
  import id_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int INST_W       = 32,
  parameter int NUM_SLOTS    = 2,
  parameter int NUM_FWD      = 2,
  parameter int LOAD_USE_LAT = 1
) (
  input logic            clk,
  input logic            reset,
  id_stage_pipe_if.slave bus
);
  logic [INST_W-1:0]              inst_r;
  logic [NUM_SLOTS*DATA_W-1:0]    slot_r;
  logic                           valid_r;
  sb_entry_t [LOAD_USE_LAT-1:0]   sb;
  logic                           hazard;
  logic                           hold;
  logic [DATA_W-1:0]              op_a;
  logic [DATA_W-1:0]              op_b;

  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < LOAD_USE_LAT; i++) begin
      if (sb[i].vld && sb[i].addr != '0 &&
          (sb[i].addr == bus.rs1_addr || sb[i].addr == bus.rs2_addr)) begin
        hazard = 1'b1;
      end
    end
    hazard = hazard & valid_r;
  end

  assign hold = bus.stall_in | hazard;

  // Scoreboard shifts every edge; a held stage injects a bubble so a stalled load is not counted twice.
  always_ff @(posedge clk) begin
    if (reset) begin
      inst_r  <= INST_W'(NOP_INST);
      slot_r  <= '0;
      valid_r <= 1'b0;
      sb      <= '0;
    end else begin
      if (bus.squash) begin
        inst_r  <= INST_W'(NOP_INST);
        slot_r  <= '0;
        valid_r <= 1'b0;
      end else if (!hold) begin
        inst_r  <= bus.inst_in;
        slot_r  <= bus.slot_in;
        valid_r <= 1'b1;
      end
      sb[0] <= sb_entry_t'{vld: valid_r & bus.is_load & ~hold, addr: bus.dest_addr};
      for (int i = 1; i < LOAD_USE_LAT; i++) begin
        sb[i] <= sb[i-1];
      end
    end
  end

  operand_bypass_mux #(.DATA_W(DATA_W), .NUM_FWD(NUM_FWD)) u_mux_a (
    .src_addr (bus.rs1_addr),
    .fwd_valid(bus.fwd_valid),
    .fwd_addr (bus.fwd_addr),
    .fwd_data (bus.fwd_data),
    .wb_we    (bus.wb_we),
    .wb_addr  (bus.wb_addr),
    .wb_data  (bus.wb_data),
    .rf_data  (bus.rf_a),
    .operand  (op_a)
  );

  operand_bypass_mux #(.DATA_W(DATA_W), .NUM_FWD(NUM_FWD)) u_mux_b (
    .src_addr (bus.rs2_addr),
    .fwd_valid(bus.fwd_valid),
    .fwd_addr (bus.fwd_addr),
    .fwd_data (bus.fwd_data),
    .wb_we    (bus.wb_we),
    .wb_addr  (bus.wb_addr),
    .wb_data  (bus.wb_data),
    .rf_data  (bus.rf_b),
    .operand  (op_b)
  );

  assign bus.inst_q       = inst_r;
  assign bus.slot_q       = slot_r;
  assign bus.valid_q      = valid_r;
  assign bus.op_a         = op_a;
  assign bus.op_b         = op_b;
  assign bus.hazard_stall = hazard;

`ifdef ID_BRANCH_RESOLVE_EN
  logic unused_imm_msbs;
  assign unused_imm_msbs   = ^bus.imm[DATA_W-1:DATA_W-2];
  assign bus.branch_taken  = valid_r & bus.is_branch & ~hazard &
                             (bus.branch_ne ? (op_a != '0) : (op_a == '0));
  assign bus.branch_target = slot_r[DATA_W-1:0] + {bus.imm[DATA_W-3:0], 2'b00};
`else
  logic unused_branch_in;
  assign unused_branch_in  = ^{bus.is_branch, bus.branch_ne, bus.imm};
  assign bus.branch_taken  = 1'b0;
  assign bus.branch_target = '0;
`endif
endmodule

// File: tb/tb_id_stage_pipe.sv
// Scoreboard bench for id_stage_pipe: directed scenarios then random cycles against a cycle-indexed load model.
module tb_id_stage_pipe;
  localparam int LAT = 2;
  localparam int NF  = 2;
  localparam logic [31:0] NOP = 32'h0000_0015;

  typedef struct packed {
    logic            rst, stall, squash;
    logic [31:0]     inst;
    logic [63:0]     slot;
    logic [4:0]      rs1, rs2, dest;
    logic            is_load;
    logic [31:0]     rf_a, rf_b;
    logic            wb_we;
    logic [4:0]      wb_addr;
    logic [31:0]     wb_data;
    logic [1:0]      fwd_valid;
    logic [1:0][4:0] fwd_addr;
    logic [1:0][31:0] fwd_data;
    logic            is_branch, branch_ne;
    logic [31:0]     imm;
  } stim_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [63:0] slot;
    logic        valid;
    logic [31:0] op_a, op_b;
    logic        haz;
    logic        bt;
    logic [31:0] btgt;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   errors  = 0;

  exp_t        exp_q[$];
  logic [31:0] m_inst;
  logic [63:0] m_slot;
  logic        m_valid;
  int          ld_cyc[$];
  logic [4:0]  ld_addr[$];
  int          cyc;

  id_stage_pipe_if #(.DATA_W(32), .INST_W(32), .NUM_SLOTS(2), .NUM_FWD(NF)) bus ();

  id_stage_pipe #(
    .DATA_W(32), .INST_W(32), .NUM_SLOTS(2), .NUM_FWD(NF), .LOAD_USE_LAT(LAT)
  ) u_dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] resolve(input logic [4:0] a, input logic [31:0] rf, input stim_t s);
    if (a == 5'd0) return rf;
    for (int i = 0; i < NF; i++)
      if (s.fwd_valid[i] && s.fwd_addr[i] == a) return s.fwd_data[i];
    if (s.wb_we && s.wb_addr == a) return s.wb_data;
    return rf;
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s.rst       = ($urandom_range(0, 99) < 2);
    s.stall     = ($urandom_range(0, 99) < 20);
    s.squash    = ($urandom_range(0, 99) < 10);
    s.inst      = $urandom;
    s.slot      = {$urandom, $urandom};
    s.rs1       = 5'($urandom_range(0, 7));
    s.rs2       = 5'($urandom_range(0, 7));
    s.dest      = 5'($urandom_range(0, 7));
    s.is_load   = ($urandom_range(0, 99) < 35);
    s.rf_a      = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
    s.rf_b      = $urandom;
    s.wb_we     = 1'($urandom_range(0, 1));
    s.wb_addr   = 5'($urandom_range(0, 7));
    s.wb_data   = $urandom;
    s.fwd_valid = 2'($urandom_range(0, 3));
    s.fwd_addr[0] = 5'($urandom_range(0, 7));
    s.fwd_addr[1] = 5'($urandom_range(0, 7));
    s.fwd_data[0] = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
    s.fwd_data[1] = $urandom;
    s.is_branch = 1'($urandom_range(0, 1));
    s.branch_ne = 1'($urandom_range(0, 1));
    s.imm       = $urandom;
    return s;
  endfunction

  task automatic drive(input stim_t s);
    reset         = s.rst;
    bus.stall_in  = s.stall;
    bus.squash    = s.squash;
    bus.inst_in   = s.inst;
    bus.slot_in   = s.slot;
    bus.rs1_addr  = s.rs1;
    bus.rs2_addr  = s.rs2;
    bus.is_load   = s.is_load;
    bus.dest_addr = s.dest;
    bus.rf_a      = s.rf_a;
    bus.rf_b      = s.rf_b;
    bus.wb_we     = s.wb_we;
    bus.wb_addr   = s.wb_addr;
    bus.wb_data   = s.wb_data;
    bus.fwd_valid = s.fwd_valid;
    bus.fwd_addr  = s.fwd_addr;
    bus.fwd_data  = s.fwd_data;
    bus.is_branch = s.is_branch;
    bus.branch_ne = s.branch_ne;
    bus.imm       = s.imm;
  endtask

  // A load that leaves decode in cycle c blocks readers of its register in cycles c+1 .. c+LAT.
  task automatic apply(input stim_t s);
    exp_t e;
    logic haz, hold;
    @(negedge clk);
    drive(s);
    haz = 1'b0;
    if (m_valid)
      foreach (ld_cyc[k])
        if (cyc - ld_cyc[k] >= 1 && cyc - ld_cyc[k] <= LAT && ld_addr[k] != 5'd0 &&
            (ld_addr[k] == s.rs1 || ld_addr[k] == s.rs2)) haz = 1'b1;
    e.inst  = m_inst;
    e.slot  = m_slot;
    e.valid = m_valid;
    e.op_a  = resolve(s.rs1, s.rf_a, s);
    e.op_b  = resolve(s.rs2, s.rf_b, s);
    e.haz   = haz;
`ifdef ID_BRANCH_RESOLVE_EN
    e.bt    = m_valid && s.is_branch && !haz && (s.branch_ne ? (e.op_a != 0) : (e.op_a == 0));
    e.btgt  = m_slot[31:0] + (s.imm << 2);
`else
    e.bt    = 1'b0;
    e.btgt  = 32'd0;
`endif
    exp_q.push_back(e);
    hold = s.stall | haz;
    if (s.rst) begin
      m_inst = NOP; m_slot = '0; m_valid = 1'b0;
      ld_cyc.delete(); ld_addr.delete();
    end else begin
      if (m_valid && s.is_load && !hold) begin
        ld_cyc.push_back(cyc); ld_addr.push_back(s.dest);
      end
      if (s.squash) begin
        m_inst = NOP; m_slot = '0; m_valid = 1'b0;
      end else if (!hold) begin
        m_inst = s.inst; m_slot = s.slot; m_valid = 1'b1;
      end
    end
    cyc++;
    while (ld_cyc.size() > 0 && cyc - ld_cyc[0] > LAT) begin
      void'(ld_cyc.pop_front()); void'(ld_addr.pop_front());
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("inst_q",        64'(bus.inst_q),        64'(e.inst));
        chk("slot_q",        bus.slot_q,             e.slot);
        chk("valid_q",       64'(bus.valid_q),       64'(e.valid));
        chk("op_a",          64'(bus.op_a),          64'(e.op_a));
        chk("op_b",          64'(bus.op_b),          64'(e.op_b));
        chk("hazard_stall",  64'(bus.hazard_stall),  64'(e.haz));
        chk("branch_taken",  64'(bus.branch_taken),  64'(e.bt));
        chk("branch_target", 64'(bus.branch_target), 64'(e.btgt));
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin : driver
    stim_t s;
    drive(idle());
    reset = 1'b1;
    m_inst = NOP; m_slot = '0; m_valid = 1'b0; cyc = 0;
    repeat (2) @(posedge clk);

    // Reset cycle, then first instruction
    s = idle(); s.rst = 1'b1; apply(s);
    s = idle(); s.inst = 32'h1234; apply(s);

    // Forwarding priority: fwd[0] beats fwd[1] beats writeback; r0 uses rf
    s = idle(); s.inst = 32'h2000;
    s.fwd_valid = 2'b11; s.fwd_addr[0] = 5'd3; s.fwd_addr[1] = 5'd3;
    s.fwd_data[0] = 32'hA; s.fwd_data[1] = 32'hB;
    s.wb_we = 1'b1; s.wb_addr = 5'd3; s.wb_data = 32'hC;
    s.rs1 = 5'd3; s.rf_a = 32'hDEAD; apply(s);
    s.rs1 = 5'd0; apply(s);
    s.fwd_valid = 2'b10; s.rs1 = 5'd3; s.rs2 = 5'd3; apply(s);
    s.fwd_valid = 2'b00; apply(s);

    // Load to r5 followed by consumer reading r5 on rs2
    s = idle(); s.inst = 32'h3000; s.is_load = 1'b1; s.dest = 5'd5; apply(s);
    s = idle(); s.inst = 32'h4000; s.rs2 = 5'd5;
    repeat (4) apply(s);

    // Stall and squash together: squash wins
    s = idle(); s.stall = 1'b1; s.squash = 1'b1; s.inst = 32'h5000; s.slot = 64'h1; apply(s);
    s = idle(); s.stall = 1'b1; apply(s);

    // Branch resolution with slot 0 = 0x100, imm = 4
    s = idle(); s.inst = 32'h6000; s.slot = 64'h0000_0000_0000_0100; apply(s);
    s = idle(); s.stall = 1'b1; s.is_branch = 1'b1; s.imm = 32'd4; s.rf_a = 32'd0; apply(s);
    s.rf_a = 32'd1; apply(s);
    s.branch_ne = 1'b1; apply(s);
    s.imm = 32'hC000_0001; apply(s);

    // Reset during a load-use stall
    s = idle(); s.inst = 32'h7000; apply(s);
    s = idle(); s.inst = 32'h7100; s.is_load = 1'b1; s.dest = 5'd5; apply(s);
    s = idle(); s.rs1 = 5'd5; apply(s);
    s.rst = 1'b1; apply(s);
    s.rst = 1'b0; apply(s);
    apply(s);

    for (int n = 0; n < 3000; n++) apply(rand_stim());

    @(negedge clk);
    #4;
    vectors++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/id_stage_pipe.md
# id_stage_pipe

Parametrised decode-stage pipeline register with operand bypass network and load-use scoreboard. Sits between fetch and execute, and holds the instruction plus NUM_SLOTS delay-slot words. It presents forwarded source operands and raises its own load-use stall. It also resolves zero/non-zero branches in decode when that feature is compiled in.

## Interface
- DATA_W, 32: datapath and register width
- INST_W, 32: instruction width
- REG_ADDR_W, 5: register address width; register 0 is hard zero
- NUM_SLOTS, 2: delay-slot words carried alongside the instruction (slot 0 = PC+4)
- NUM_FWD, 2: forwarding sources; index 0 is youngest and has highest priority
- LOAD_USE_LAT, 1: cycles a load result is unavailable after leaving decode (1..4)
- NOP_INST, 32'h00000015: encoding inserted on squash and reset

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- stall_in  in  1  downstream stall; holds the stage
- squash  in  1  kill the instruction entering decode next edge
- inst_in  in  INST_W  instruction from fetch
- slot_in  in  NUM_SLOTS*DATA_W  delay-slot words from fetch
- inst_q  out  INST_W  registered instruction, to external decoder
- slot_q  out  NUM_SLOTS*DATA_W  registered slot words
- valid_q  out  1  registered instruction is live
- rs1_addr, rs2_addr  in  REG_ADDR_W each  source addresses from decoder
- is_load  in  1  decoded instruction is a load
- dest_addr  in  REG_ADDR_W  load destination
- rf_a, rf_b  in  DATA_W each  raw register-file reads
- wb_we, wb_addr, wb_data  in  1/REG_ADDR_W/DATA_W  writeback port
- fwd_valid  in  NUM_FWD  forwarding entry carries a result
- fwd_addr  in  NUM_FWD*REG_ADDR_W  forwarding destinations
- fwd_data  in  NUM_FWD*DATA_W  forwarding results
- op_a, op_b  out  DATA_W each  resolved operands
- hazard_stall  out  1  load-use stall request
- is_branch, branch_ne, imm  in  1/1/DATA_W  branch decode (feature only)
- branch_taken  out  1; branch_target  out  DATA_W

## Operation
- Internal hold `hold = stall_in | hazard_stall`.
- Register update priority: reset > squash > hold > load.
  - squash loads inst_q=NOP_INST, slot_q=0, valid_q=0, even while held.
  - Otherwise, when hold is low, the register takes inst_in/slot_in and sets valid_q=1.
- Operand resolution for op_a, op_b, each independently:
  - Source address 0 always takes the rf value.
  - Otherwise the first match wins, in this order: lowest-index fwd entry with fwd_valid and equal address, then wb bypass (wb_we and equal address), then rf.
- Scoreboard: a shift chain of LOAD_USE_LAT entries, each {valid, addr}.
  - Every edge the chain shifts. Entry 0 takes {valid_q & is_load & ~hold, dest_addr}.
  - While held, a bubble (valid=0) enters the chain.
  - hazard_stall = valid_q & a valid entry whose non-zero addr equals rs1_addr or rs2_addr.
  - Squash does not clear the scoreboard; in-flight older loads remain tracked. Reset empties it.
- hazard_stall is independent of stall_in. The stage asserts it even while stall_in is high.

## Timing
- Reset values: inst_q=NOP_INST, slot_q=0, valid_q=0, scoreboard empty, hazard_stall=0, branch_taken=0.
- inst_q, slot_q and valid_q have 1-cycle latency from input.
- op_a, op_b, hazard_stall, branch_taken and branch_target are combinational from registered state and current inputs, with 0 added latency.
- A load followed directly by a dependent instruction stalls exactly LOAD_USE_LAT cycles.
- Squash and stall_in in the same cycle: squash wins.
- Reset asserted mid-stall: all state returns to reset values next edge.

## Configuration
- ID_BRANCH_RESOLVE_EN defined:
  - branch_taken = valid_q & is_branch & ~hazard_stall & (branch_ne ? op_a!=0 : op_a==0).
  - branch_target = slot 0 + {imm[DATA_W-3:0],2'b00}, wrapping modulo 2^DATA_W.
- Undefined: branch_taken=0, branch_target=0, and is_branch, branch_ne and imm are ignored.

## Structure
- Package id_pkg holds NOP_INST, REG_ADDR_W and the scoreboard-entry struct type.
- Sub-module operand_bypass_mux performs priority selection for one operand. It is instantiated twice.

## Test plan
- Reset, then inst_in=0x1234 with no stall → next edge: inst_q=0x1234, valid_q=1; before that edge: inst_q=0x15, valid_q=0.
- fwd[0] and fwd[1] both valid for r3 with 0xA/0xB, wb also r3=0xC, rs1=3 → op_a=0xA. With rs1=0 → op_a=rf_a.
- Load to r5, then consumer with rs2=5 and LOAD_USE_LAT=2 → hazard_stall high for 2 cycles, inst_q held, then released.
- stall_in=1 and squash=1 together → inst_q=0x15, valid_q=0, slot_q=0.
- With ID_BRANCH_RESOLVE_EN: op_a=0, branch_ne=0, slot 0=0x100, imm=4 → branch_taken=1, target=0x110. With op_a=1 → branch_taken=0.
- Assert reset during a load-use stall → next edge: hazard_stall=0, valid_q=0.
